// File: rtl/bootrom_loader_pkg.sv
// Shared constants and helpers for the boot ROM loader.
// Pure declarations, no logic, no latency.
// No flow control of its own.
`include "defines.sv"

package bootrom_loader_pkg;

   localparam int LEN_BYTES  = `BootLdLenBytes;
   localparam int WORD_BYTES = `BootLdWordBytes;

   typedef logic [7:0] byte_t;

   // Bits needed to represent value (value=15 -> 4, value=65535 -> 16)
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         v = v >> 1;
         r = r + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

   // Running checksum is a plain byte sum, wrapping mod 256
   function automatic byte_t csum_add(input byte_t acc, input byte_t b);
      return acc + b;
   endfunction

endpackage

// File: rtl/bootrom_loader_pack.sv
// Little-endian byte-to-word packer shared by the length and data fields.
// word_vld/word_dat are combinational in the cycle the 4th byte is accepted.
// No backpressure: in_vld must only pulse on an accepted byte.
`include "defines.sv"

module bootrom_loader_pack
   import bootrom_loader_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            in_vld,
   input  logic [7:0]      in_dat,
   output logic            word_vld,
   output logic [`InstBus] word_dat
);

   logic [1:0]  cnt;
   logic [23:0] sh;

   // Completed word = current byte on top of the three earlier bytes
   assign word_vld = in_vld && (cnt == 2'(WORD_BYTES - 1));
   assign word_dat = {in_dat, sh};

   // Shift each accepted byte in from the top so the first byte ends at bits 7:0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
         sh  <= 24'd0;
      end else if (clear) begin
         cnt <= 2'd0;
         sh  <= 24'd0;
      end else if (in_vld) begin
         cnt <= cnt + 2'd1;
         sh  <= {in_dat, sh[23:8]};
      end
   end

endmodule

// File: rtl/defines.sv
`ifndef BOOTROM_LOADER_DEFINES_SV
`define BOOTROM_LOADER_DEFINES_SV

// Instruction bus range, used as [`InstBus]
`define InstBus 31:0

// Boot loader framing: length field bytes and bytes per instruction word
`define BootLdLenBytes  4
`define BootLdWordBytes 4

`endif

// File: rtl/bootrom_loader.sv
// Boot ROM writer: length word, data words, checksum byte from a byte stream.
// 4 cycles per word accepted plus 1 write cycle; wen/waddr/wdata registered.
// rx_ready decoded from state only; rx_valid gaps simply stall, nothing times out.
`include "defines.sv"

module bootrom_loader
   import bootrom_loader_pkg::*;
#(
   parameter int RAM_DEPTH = 65536,
   localparam int AW = clogb2(RAM_DEPTH - 1)
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            rx_ready,
   output logic            wen,
   output logic [AW-1:0]   waddr,
   output logic [`InstBus] wdata,
   output logic            busy,
   output logic            hold,
   output logic            done,
   output logic            err
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LEN   = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] CHK   = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [31:0] DEPTH32 = 32'(RAM_DEPTH);

   logic [2:0]      state;
   logic [31:0]     nwords;
   byte_t           csum;
   logic            acc;
   logic            start_ok;
   logic            pk_vld;
   logic [`InstBus] pk_word;

   assign rx_ready = (state == LEN) || (state == DATA) || (state == CHK);
   assign acc      = rx_valid && rx_ready;
   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign hold     = busy;

   bootrom_loader_pack u_pack (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start_ok),
      .in_vld   (acc && (state != CHK)),
      .in_dat   (rx_data),
      .word_vld (pk_vld),
      .word_dat (pk_word)
   );

   // Load sequencer: framing, write strobes, address/word counting and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         wen    <= 1'b0;
         waddr  <= '0;
         wdata  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         nwords <= 32'd0;
         csum   <= 8'd0;
      end else begin
         wen <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= LEN;
                  done  <= 1'b0;
                  err   <= 1'b0;
                  waddr <= '0;
                  csum  <= 8'd0;
                  busy  <= 1'b1;
               end
            end
            LEN: begin
               if (pk_vld) begin
                  nwords <= pk_word;
                  if (pk_word == 32'd0) begin
                     state <= CHK;
                  end else if (pk_word > DEPTH32) begin
                     // Oversize: abort without consuming a checksum byte
                     err   <= 1'b1;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (acc) csum <= csum_add(csum, rx_data);
               if (pk_vld) begin
                  wdata <= pk_word;
                  wen   <= 1'b1;
                  state <= WRITE;
               end
            end
            WRITE: begin
               // Address wraps mod 2^AW; the wrapped value is never written
               waddr  <= waddr + 1'b1;
               nwords <= nwords - 32'd1;
               state  <= (nwords == 32'd1) ? CHK : DATA;
            end
            CHK: begin
               if (acc) begin
                  err   <= (rx_data != csum);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bootrom_loader.sv
module tb_bootrom_loader;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          busy;
   logic          hold;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;
   int gap_mode = 0;
   logic [AW+31:0] exp_q[$];
   logic [31:0]    wbuf[DEPTH];

   bootrom_loader #(.RAM_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .hold     (hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, expv);
      end
   endtask

   // Monitor: every write strobe is popped against the scoreboard
   always @(negedge clk) begin
      if (wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", waddr, wdata);
         end else begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            check("write_addr", 32'(waddr), 32'(e[AW+31:32]));
            check("write_data", wdata, e[31:0]);
         end
         check("wen_with_rx_ready", 32'(rx_ready), 32'd0);
      end
   end

   task automatic push_write(input int addr, input logic [31:0] data);
      exp_q.push_back({AW'(addr), data});
   endtask

   // Called at a negedge; returns at the negedge after the byte transferred
   task automatic send_byte(input logic [7:0] b);
      int  g;
      bit  got;
      g = (gap_mode != 0) ? int'($urandom_range(0, 2)) : 0;
      if (g > 0) begin
         rx_valid = 1'b0;
         repeat (g) @(negedge clk);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         if (rx_ready) begin
            @(posedge clk);
            got = 1'b1;
         end
         @(negedge clk);
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_timeout: got rx_ready=0 for 50 cycles, required a transfer of %h", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic idle_rx();
      rx_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic exp_err);
      int t;
      t = 0;
      while (!done && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, 32'(hold), 32'd0);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Full framed load of n words from wbuf with an explicit checksum byte
   task automatic load(input string tag, input int n, input logic [7:0] cs, input logic exp_err);
      for (int i = 0; i < n; i++) push_write(i, wbuf[i]);
      start_pulse();
      send_word(32'(n));
      for (int i = 0; i < n; i++) send_word(wbuf[i]);
      send_byte(cs);
      idle_rx();
      wait_done(tag, exp_err);
   endtask

   initial begin
      logic [7:0] cs;

      repeat (2) @(negedge clk);
      check("rst_wen", 32'(wen), 32'd0);
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. nominal two-word load
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'hDEADBEEF;
      load("nominal", 2, 8'h4C, 1'b0);

      // 2. bad checksum still writes both words
      load("badcsum", 2, 8'h4D, 1'b1);

      // 3. zero length, good and bad checksum
      load("zero_ok", 0, 8'h00, 1'b0);
      load("zero_bad", 0, 8'h01, 1'b1);

      // 4. oversize length aborts immediately
      start_pulse();
      send_word(32'd17);
      idle_rx();
      check("oversize_done", 32'(done), 32'd1);
      check("oversize_err", 32'(err), 32'd1);
      check("oversize_rx_ready", 32'(rx_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("oversize_rx_ready_later", 32'(rx_ready), 32'd0);
      check("oversize_no_write", 32'(exp_q.size()), 32'd0);

      // 4b. full-depth load fills addresses 0..15
      cs = 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
         wbuf[i] = 32'hA0B0C0D0 + 32'h01020304 * i;
         for (int k = 0; k < 4; k++) cs = cs + wbuf[i][8*k +: 8];
      end
      load("fulldepth", DEPTH, cs, 1'b0);

      // 5. random rx_valid gaps plus an ignored mid-load start
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'hDEADBEEF;
      gap_mode = 1;
      push_write(0, wbuf[0]);
      push_write(1, wbuf[1]);
      start_pulse();
      send_word(32'd2);
      send_word(wbuf[0]);
      send_byte(8'hEF);
      send_byte(8'hBE);
      idle_rx();
      start_pulse();
      check("midstart_busy", 32'(busy), 32'd1);
      send_byte(8'hAD);
      send_byte(8'hDE);
      send_byte(8'h4C);
      idle_rx();
      gap_mode = 0;
      wait_done("gaps", 1'b0);

      // 6. reset after first word is written
      push_write(0, wbuf[0]);
      start_pulse();
      send_word(32'd2);
      send_word(wbuf[0]);
      idle_rx();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_wen", 32'(wen), 32'd0);
      check("arst_waddr", 32'(waddr), 32'd0);
      check("arst_wdata", wdata, 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hold", 32'(hold), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      check("arst_rx_ready", 32'(rx_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_pending_writes", 32'(exp_q.size()), 32'd0);
      load("after_reset", 2, 8'h4C, 1'b0);

      repeat (3) @(negedge clk);
      check("final_pending_writes", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bootrom_loader.md
Name: bootrom_loader

Overview:
- Writer side of the boot ROM write port: takes a byte stream from a serial receiver over a valid/ready handshake.
- Packs bytes little-endian into 32-bit instruction words and drives wen/din/addr into the boot ROM one word at a time, from address 0 upward.
- Framing: 4-byte word count, the data words, then one 8-bit checksum byte.
- Holds the core in reset (hold) while a load is in progress.

Parameters:
- RAM_DEPTH, 65536, boot ROM depth in words; address width AW = clogb2(RAM_DEPTH-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load; ignored while busy
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid & rx_ready at the clk edge
- wen  out  1  boot ROM write enable, one cycle per word
- waddr  out  AW  boot ROM write address
- wdata  out  `InstBus  boot ROM write data
- busy  out  1  load in progress
- hold  out  1  core hold request, equal to busy
- done  out  1  load finished; level output
- err  out  1  load failed (length or checksum); valid when done=1

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, and wen, waddr, wdata, busy, done, err, byte counter, word counter and checksum accumulator all cleared to 0.
- rx_ready is decoded from the state register only, with no combinational path from rx_valid. It is 1 in LEN, DATA and CHK, and 0 otherwise.
- wen, waddr and wdata are registered.
- IDLE / DONE: a start pulse goes to LEN and clears done, err, waddr, byte counter and checksum; busy is set to 1.
- LEN: accepts 4 bytes (first byte = bits 7:0) into a 32-bit word count N.
  - N == 0: go to CHK.
  - N > RAM_DEPTH: set err, go to DONE; no writes occur and no checksum byte is consumed.
  - Otherwise: go to DATA.
- DATA: accepts 4 bytes LE into a shift/pack register, and each accepted byte is added mod 256 to the checksum. The cycle after the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - wen = 1, wdata = packed word, waddr = current address; rx_ready = 0.
  - On exit, waddr increments and N decrements.
  - N reaches 0: go to CHK; else go to DATA.
- Per-word cost is 5 cycles minimum with rx_valid held high. rx_valid gaps stall only the byte counter; nothing times out.
- Address arithmetic: waddr is AW bits and increments mod 2^AW. N == RAM_DEPTH is legal: the last write is at RAM_DEPTH-1, and the wrap to 0 is never used for a write.
- CHK: accepts 1 byte; err = (byte != checksum[7:0]). Go to DONE.
- DONE: busy = 0, hold = 0, done = 1, held until the next start. err holds its value until the next start.
- start in any state other than IDLE/DONE is ignored and has no effect on counters.
- wen is never asserted outside WRITE. wen deasserts the cycle after WRITE, even if rx_valid is held.
- Reset mid-load aborts immediately with no further writes. Words already written remain in the ROM.

Decomposition:
- The data-width macro `InstBus comes from defines.v.
- Add to defines.v: `BootLdLenBytes (4) and `BootLdWordBytes (4).
- State encoding uses local constants in the module: IDLE, LEN, DATA, WRITE, CHK, DONE, one-hot or 3-bit binary.
- clogb2 is duplicated as a local function.
- One natural sub-module: bootrom_loader_pack, a byte-to-word LE packer with a 2-bit byte counter, word_valid pulse and clear input. It is used for both the LEN and DATA fields.

Test Plan:
1. Nominal load: start, then bytes 02 00 00 00 78 56 34 12 EF BE AD DE 4C with rx_valid always 1.
   - Expect wen pulse with waddr=0, wdata=0x12345678, then waddr=1, wdata=0xDEADBEEF.
   - Expect done=1, err=0, busy and hold low after CHK.
2. Bad checksum: same stream with the final byte 0x4D.
   - Both words are still written; done=1, err=1.
3. Zero length: bytes 00 00 00 00 00.
   - No wen; done=1, err=0.
   - Length bytes 00 00 00 00 then checksum 01 gives err=1.
4. Oversize length with RAM_DEPTH=16: bytes 11 00 00 00.
   - No wen; done=1, err=1 immediately; rx_ready=0 afterward.
   - N=16 loads 16 words to addresses 0..15 with err=0.
5. Handshake gaps: random rx_valid deassertion plus a start pulse mid-load.
   - Identical written words and addresses to scenario 1; the mid-load start is ignored.
   - wen never high while rx_ready=1.
6. Reset mid-load: rst_n low after 1 word is written.
   - All outputs read 0 asynchronously with no further wen.
   - A subsequent start with scenario 1 completes correctly.
